// File: rtl/input_buffer_sequencer.sv
// Activation input buffer controller: optionally loads one input vector into the
// buffer, then replays it neuronFold times in synapse-fold order downstream.
module input_buffer_sequencer #(
    parameter int address_width       = 12,
    parameter int synopseFold         = 18,
    parameter int neuronFold          = 16,
    parameter int simd_width          = 32,
    parameter int binary_input_levels = 2,
    localparam int W   = simd_width * binary_input_levels,
    localparam int NFW = (neuronFold > 1) ? $clog2(neuronFold) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     load_en,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    output logic                     in_ready,
    output logic                     buf_enable,
    output logic                     buf_rwEn,
    output logic [address_width-1:0] buf_address,
    output logic [W-1:0]             buf_wdata,
    output logic                     buf_wdrive,
    input  logic [W-1:0]             buf_rdata,
    input  logic                     buf_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic                     out_sf_last,
    output logic                     out_frame_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               dbg_state_o
);

    // Handshakes: a word moves on a cycle where valid and ready are both high;
    // once out_valid is raised, out_data and the last flags hold until accepted.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RD_REQ   = 3'd2,
        RD_WAIT  = 3'd3,
        OUT_HOLD = 3'd4,
        DONE     = 3'd5
    } state_e;

    localparam logic [address_width-1:0] SF_LAST = address_width'(synopseFold - 1);
    localparam logic [NFW-1:0]           NF_LAST = NFW'(neuronFold - 1);

    state_e                   state_q, state_d;
    logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [address_width-1:0] sf_q, sf_d;
    logic [NFW-1:0]           nf_q, nf_d;
    logic [W-1:0]             out_data_q, out_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            sf_q       <= '0;
            nf_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            sf_q       <= sf_d;
            nf_q       <= nf_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        sf_d        = sf_q;
        nf_d        = nf_q;
        out_data_d  = out_data_q;
        in_ready    = 1'b0;
        buf_enable  = 1'b0;
        buf_rwEn    = 1'b1;
        buf_address = sf_q;
        buf_wdata   = '0;
        buf_wdrive  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = load_en ? LOAD : RD_REQ;
                    wr_ptr_d = '0;
                    sf_d     = '0;
                    nf_d     = '0;
                end
            end
            LOAD: begin
                in_ready    = 1'b1;
                buf_address = wr_ptr_q;
                if (in_valid) begin
                    buf_enable = 1'b1;
                    buf_rwEn   = 1'b0;
                    buf_wdata  = in_data;
                    buf_wdrive = 1'b1;
                    // Pointer stops at the last fold so it never addresses unused words.
                    if (wr_ptr_q == SF_LAST) begin
                        wr_ptr_d = '0;
                        state_d  = RD_REQ;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                buf_enable = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (buf_ready) begin
                    out_data_d = buf_rdata;
                    state_d    = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                if (out_ready) begin
                    if (sf_q != SF_LAST) begin
                        sf_d    = sf_q + 1'b1;
                        state_d = RD_REQ;
                    end else begin
                        sf_d = '0;
                        if (nf_q != NF_LAST) begin
                            nf_d    = nf_q + 1'b1;
                            state_d = RD_REQ;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                nf_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid      = (state_q == OUT_HOLD);
    assign out_data       = out_data_q;
    assign out_sf_last    = out_valid && (sf_q == SF_LAST);
    assign out_frame_last = out_sf_last && (nf_q == NF_LAST);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_input_buffer_sequencer.sv
// Bench for input_buffer_sequencer: buffer memory model, upstream/downstream drivers,
// and a scoreboard built from the expected replay order of each frame.
module tb_input_buffer_sequencer;

    localparam int AW   = 12;
    localparam int SF   = 4;
    localparam int NF   = 2;
    localparam int SIMD = 32;
    localparam int BIL  = 2;
    localparam int W    = SIMD * BIL;

    logic          clk = 1'b0;
    logic          rst, start, load_en, in_valid, in_ready;
    logic [W-1:0]  in_data, buf_wdata, buf_rdata, out_data;
    logic          buf_enable, buf_rwEn, buf_wdrive, buf_ready;
    logic [AW-1:0] buf_address;
    logic          out_valid, out_sf_last, out_frame_last, out_ready, busy, done;
    logic [2:0]    dbg_state;

    input_buffer_sequencer #(
        .address_width(AW), .synopseFold(SF), .neuronFold(NF),
        .simd_width(SIMD), .binary_input_levels(BIL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .buf_enable(buf_enable), .buf_rwEn(buf_rwEn), .buf_address(buf_address),
        .buf_wdata(buf_wdata), .buf_wdrive(buf_wdrive), .buf_rdata(buf_rdata),
        .buf_ready(buf_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sf_last(out_sf_last), .out_frame_last(out_frame_last),
        .out_ready(out_ready), .busy(busy), .done(done), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Environment and scoreboard state
    logic [W-1:0]   mem[SF];
    logic [W+1:0]   exp_q[$];
    logic [W-1:0]   src_q[$];
    int             exp_wr_q[$];
    int             wr_total = 0, done_cnt = 0, hs_cnt = 0;
    bit             rd_pend = 0;
    int             rd_addr = 0, rd_cnt = 0, rd_min = 0, rd_max = 0;
    int             iv_pct = 100, or_pct = 100;
    bit             iv_toggle = 0, tog = 0;
    int             stall_word = -1, stall_left = 0;
    bit             prev_stall = 0;
    logic [W-1:0]   prev_data;
    bit             mon_en = 0;

    // Buffer model: read data appears with buf_ready after the programmed delay
    always @(posedge clk) begin
        #1;
        buf_ready = 1'b0;
        buf_rdata = {$urandom, $urandom};
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                buf_ready = 1'b1;
                buf_rdata = mem[rd_addr];
                rd_pend   = 0;
            end else begin
                rd_cnt--;
            end
        end
    end

    // Upstream driver
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        if (src_q.size() > 0 && (iv_toggle ? tog : ($urandom_range(99) < iv_pct))) begin
            in_valid = 1'b1;
            in_data  = src_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
        end
    end

    // Downstream driver with an optional stall on one chosen word
    always @(posedge clk) begin
        #1;
        if (out_valid && stall_word == hs_cnt + 1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = ($urandom_range(99) < or_pct);
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst && mon_en) begin
            if (buf_enable) check("addr_range", buf_address < SF, 1);
            if (in_valid && in_ready) check("wr_on_accept", buf_enable && !buf_rwEn && buf_wdrive, 1);
            if (buf_wdrive) check("wdrive_qual", buf_enable && !buf_rwEn, 1);
            if (buf_enable && !buf_rwEn) begin
                wr_total++;
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", buf_address, exp_wr_q.pop_front());
                end
                if (src_q.size() > 0) check("wr_data", buf_wdata, src_q.pop_front());
                if (buf_address < SF) mem[int'(buf_address)] = buf_wdata;
            end
            if (buf_enable && buf_rwEn) begin
                check("rd_overlap", rd_pend, 0);
                rd_pend = 1;
                rd_addr = (buf_address < SF) ? int'(buf_address) : 0;
                rd_cnt  = $urandom_range(rd_max, rd_min);
            end else if (rd_pend) begin
                check("wait_no_valid", out_valid, 0);
            end
            if (out_valid) begin
                if (prev_stall) begin
                    check("hold_data", out_data, prev_data);
                    check("hold_no_rd", buf_enable, 0);
                end
                if (out_ready) begin
                    hs_cnt++;
                    prev_stall = 0;
                    if (exp_q.size() == 0) begin
                        check("extra_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e[W-1:0]);
                        check("sf_last", out_sf_last, e[W]);
                        check("frame_last", out_frame_last, e[W+1]);
                    end
                end else begin
                    prev_stall = 1;
                    prev_data  = out_data;
                end
            end else begin
                prev_stall = 0;
            end
            if (done) begin
                check("done_q_empty", exp_q.size(), 0);
                done_cnt++;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_buf_enable"}, buf_enable, 0);
        check({tag, "_wdrive"}, buf_wdrive, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_lasts"}, {out_sf_last, out_frame_last}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Reference: the frame is SF words replayed NF times in fold order
    task automatic prep(input bit load, input bit fixed, input logic [W-1:0] base);
        logic [W-1:0] mdl[SF];
        logic [W-1:0] v;
        exp_wr_q.delete();
        for (int i = 0; i < SF; i++) begin
            if (load) begin
                v = fixed ? base + W'(i) : {$urandom, $urandom};
                src_q.push_back(v);
                exp_wr_q.push_back(i);
                mdl[i] = v;
            end else begin
                mdl[i] = mem[i];
            end
        end
        for (int n = 0; n < NF; n++)
            for (int s = 0; s < SF; s++)
                exp_q.push_back({1'(n == NF-1 && s == SF-1), 1'(s == SF-1), mdl[s]});
    endtask

    task automatic frame(input bit load, input int mid_start, input int rst_at);
        int d0 = done_cnt;
        int w0 = wr_total;
        int c  = 0;
        bit fin = 0;
        bit aborted = 0;
        @(negedge clk); #1;
        start = 1'b1; load_en = load;
        @(negedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        check("busy_after_start", busy, 1);
        while (!fin) begin
            @(negedge clk); #1;
            c++;
            start   = (c == mid_start);
            load_en = (c == mid_start);
            if (rst_at > 0 && c == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                #1;
                check_idle("mid_reset");
                rst = 1'b0;
                exp_q.delete(); src_q.delete(); exp_wr_q.delete();
                rd_pend = 0; prev_stall = 0;
                aborted = 1; fin = 1;
            end else if (done_cnt != d0) begin
                fin = 1;
            end else if (c > 3000) begin
                check("frame_timeout", 1, 0);
                fin = 1;
            end
        end
        start = 1'b0; load_en = 1'b0;
        if (!aborted) begin
            check("done_once", done_cnt - d0, 1);
            check("writes", wr_total - w0, load ? SF : 0);
            check("wr_q_empty", exp_wr_q.size(), 0);
            @(negedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
        end else begin
            check("no_done_on_reset", done_cnt - d0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_en = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        buf_ready = 1'b0; buf_rdata = '0;
        for (int i = 0; i < SF; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        mon_en = 1;

        // Full frame with load
        prep(1, 1, 'hA0);
        frame(1, 0, 0);

        // Replay of preinitialised contents
        for (int i = 0; i < SF; i++) mem[i] = W'((i + 1) * 'h11);
        prep(0, 0, '0);
        frame(0, 0, 0);

        // Backpressure on word 2
        stall_word = hs_cnt + 2; stall_left = 5;
        prep(0, 0, '0);
        frame(0, 0, 0);
        check("stall_used", stall_left, 0);
        stall_word = -1;

        // Slow upstream
        iv_toggle = 1;
        prep(1, 1, 'hB0);
        frame(1, 0, 0);
        iv_toggle = 0;

        // Slow buffer plus a start pulse mid-frame
        rd_min = 3; rd_max = 3;
        prep(1, 0, '0);
        frame(1, 10, 0);
        rd_min = 0; rd_max = 0;

        // Reset during replay, then a fresh replay frame
        prep(0, 0, '0);
        frame(0, 0, 12);
        prep(0, 0, '0);
        frame(0, 0, 0);

        // Randomised frames
        for (int k = 0; k < 8; k++) begin
            bit ld;
            ld     = 1'($urandom_range(1));
            iv_pct = $urandom_range(100, 30);
            or_pct = $urandom_range(100, 30);
            rd_max = $urandom_range(2);
            prep(ld, 0, '0);
            frame(ld, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
